// File: rtl/registro_switches_pkg.sv
// Shared constants for the switch/button status register peripheral.
package registro_switches_pkg;

  // Layout of the memory-mapped status word.
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned SW_LSB  = 0;
  localparam int unsigned BTN_LSB = 16;

  // Default sizing of the peripheral.
  localparam int unsigned N_SWITCHES_DEF      = 16;
  localparam int unsigned N_BUTTONS_DEF       = 4;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 256;

  // One extra bit beyond what DEBOUNCE_CYCLES-1 needs, so the counter can
  // saturate well before it could ever wrap.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// One push-button: 2-FF synchroniser followed by a stable-state debouncer.
// A new level is accepted only after it has differed from the stable state
// for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle restarts the count.
module button_debouncer
  import registro_switches_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clck_i,
  input  logic rst_i,
  input  logic boton_i,
  output logic estado_o
);

  localparam int unsigned      CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic             meta_q, meta_d;
  logic             sync_q, sync_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state: synchroniser shift, then count disagreement with the stable level.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no path can infer a latch.
    meta_d   = boton_i;
    sync_d   = meta_q;
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync_q != stable_q) begin
      if (cnt_q >= CNT_LAST) begin
        stable_d = sync_q;
        cnt_d    = '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        cnt_d = cnt_q;
      end
    end
  end

  // State registers with synchronous active-low clear.
  always_ff @(posedge clck_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_i) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      meta_q   <= meta_d;
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign estado_o = stable_q;

endmodule

// File: rtl/registro_switches_ctrl.sv
// Input peripheral: synchronised switches and debounced buttons packed into
// one read-only 32-bit status word. Level-based, no sticky or edge flags.
module registro_switches_ctrl
  import registro_switches_pkg::*;
#(
  parameter int unsigned N_SWITCHES      = N_SWITCHES_DEF,
  parameter int unsigned N_BUTTONS       = N_BUTTONS_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic                  clck_i,
  input  logic                  rst_i,
  input  logic [N_SWITCHES-1:0] switches_i,
  input  logic [N_BUTTONS-1:0]  botones_i,
  output logic [WORD_W-1:0]     registro_switches_o
);

  logic [N_SWITCHES-1:0] sw_meta_q, sw_meta_d;
  logic [N_SWITCHES-1:0] sw_sync_q, sw_sync_d;
  logic [N_BUTTONS-1:0]  btn_stable;
  logic [WORD_W-1:0]     word_q, word_d;

  // One independent debouncer per button.
  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .clck_i  (clck_i),
      .rst_i   (rst_i),
      .boton_i (botones_i[i]),
      .estado_o(btn_stable[i])
    );
  end

  // Switch synchroniser shift and assembly of the status word; unused bits stay 0.
  always_comb begin
    sw_meta_d = switches_i;
    sw_sync_d = sw_meta_q;
    word_d    = '0;
    word_d[SW_LSB  +: N_SWITCHES] = sw_sync_q;
    word_d[BTN_LSB +: N_BUTTONS]  = btn_stable;
  end

  // Switch synchroniser and output register with synchronous active-low clear.
  always_ff @(posedge clck_i) begin
    if (!rst_i) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      word_q    <= '0;
    end else begin
      sw_meta_q <= sw_meta_d;
      sw_sync_q <= sw_sync_d;
      word_q    <= word_d;
    end
  end

  assign registro_switches_o = word_q;

endmodule

// File: tb/tb_registro_switches_ctrl.sv
// Scoreboard bench: the stimulus side pushes the expected word for every edge
// into a queue; a separate monitor pops and compares after every edge.
module tb_registro_switches_ctrl;

  localparam int D   = 256;
  localparam int LAT = 2 + D + 1;

  logic        clck_i = 1'b1;
  logic        rst_i  = 1'b0;
  logic [15:0] switches_i = '0;
  logic [3:0]  botones_i  = '0;
  logic [31:0] registro_switches_o;

  registro_switches_ctrl dut (
    .clck_i             (clck_i),
    .rst_i              (rst_i),
    .switches_i         (switches_i),
    .botones_i          (botones_i),
    .registro_switches_o(registro_switches_o)
  );

  always #5 clck_i = ~clck_i;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];

  // Reference model: inputs reach the word two edges after being sampled;
  // a button level is accepted once the seen stream has shown the opposite
  // level for D consecutive samples, and is published one edge later.
  logic [15:0] m_sw_h1 = '0, m_sw_h2 = '0;
  logic [3:0]  m_bt_h1 = '0, m_bt_h2 = '0;
  logic [3:0]  m_level = '0, m_run_val = '0;
  int          m_run_len[4] = '{0, 0, 0, 0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic rst, input logic [15:0] sw, input logic [3:0] bt);
    logic [3:0] seen;
    if (!rst) begin
      exp_q.push_back(32'h0);
      m_sw_h1 = '0; m_sw_h2 = '0; m_bt_h1 = '0; m_bt_h2 = '0;
      m_level = '0; m_run_val = '0;
      for (int i = 0; i < 4; i++) m_run_len[i] = 0;
    end else begin
      exp_q.push_back({12'h0, m_level, m_sw_h2});
      seen = m_bt_h2;
      for (int i = 0; i < 4; i++) begin
        if (seen[i] == m_run_val[i]) m_run_len[i]++;
        else begin
          m_run_val[i] = seen[i];
          m_run_len[i] = 1;
        end
        if (m_run_val[i] != m_level[i] && m_run_len[i] >= D) m_level[i] = m_run_val[i];
      end
      m_sw_h2 = m_sw_h1; m_sw_h1 = sw;
      m_bt_h2 = m_bt_h1; m_bt_h1 = bt;
    end
  endtask

  // Drive one edge's inputs on the falling edge, record the expectation,
  // and return 1 time unit after the rising edge.
  task automatic tick(input logic rst, input logic [15:0] sw, input logic [3:0] bt);
    @(negedge clck_i);
    rst_i      = rst;
    switches_i = sw;
    botones_i  = bt;
    model_edge(rst, sw, bt);
    @(posedge clck_i);
    #1;
  endtask

  // Monitor: one output word per edge, compared against the queue head.
  initial begin
    forever begin
      @(posedge clck_i);
      #1;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard_underflow: got an output word with no expectation queued (t=%0t)", $time);
      end else begin
        check("word", registro_switches_o, exp_q.pop_front());
      end
    end
  end

  // Press then release button b; measure both latencies and watch other bits.
  task automatic press_release(input int b);
    int   rise_n, fall_n;
    logic other;
    logic [3:0] mask;
    mask   = 4'(1 << b);
    rise_n = 0; fall_n = 0; other = 1'b0;
    for (int n = 1; n <= 600; n++) begin
      tick(1'b1, 16'h0, mask);
      if (rise_n == 0 && registro_switches_o[16+b]) rise_n = n;
      if ((registro_switches_o[19:16] & ~mask) != 4'h0) other = 1'b1;
    end
    check($sformatf("press_latency_b%0d", b), rise_n, LAT);
    for (int n = 1; n <= 600; n++) begin
      tick(1'b1, 16'h0, 4'h0);
      if (fall_n == 0 && !registro_switches_o[16+b]) fall_n = n;
      if ((registro_switches_o[19:16] & ~mask) != 4'h0) other = 1'b1;
    end
    check($sformatf("release_latency_b%0d", b), fall_n, LAT);
    check($sformatf("others_quiet_b%0d", b), {31'h0, other}, 32'h0);
  endtask

  initial begin
    int          rise_n;
    logic        early;
    logic [15:0] prev_v, sw;
    logic [3:0]  bt;
    int          hold[4];

    // Reset with nonzero inputs.
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 16'hA5C3, 4'hF);
      check("reset_word", registro_switches_o, 32'h0);
    end
    for (int i = 0; i < 4; i++) tick(1'b1, 16'h0, 4'h0);

    // Switch sweep, each value held for 2 edges.
    prev_v = 16'h0;
    for (int v = 0; v <= 65535; v += 257) begin
      tick(1'b1, 16'(v), 4'h0);
      if (v != 0) check("sweep_3_edges", registro_switches_o, {16'h0, prev_v});
      tick(1'b1, 16'(v), 4'h0);
      prev_v = 16'(v);
    end
    for (int i = 0; i < 3; i++) tick(1'b1, 16'h0, 4'h0);

    // Each button, press and release.
    for (int b = 0; b < 4; b++) press_release(b);

    // Bounce on button 2, then hold high.
    early = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick(1'b1, 16'h0, ((i / 10) % 2 == 0) ? 4'b0100 : 4'b0000);
      if (registro_switches_o[18]) early = 1'b1;
    end
    check("bounce_ignored", {31'h0, early}, 32'h0);
    rise_n = 0;
    for (int n = 1; n <= 300; n++) begin
      tick(1'b1, 16'h0, 4'b0100);
      if (rise_n == 0 && registro_switches_o[18]) rise_n = n;
    end
    check("bounce_latency", rise_n, LAT);
    for (int n = 0; n < 300; n++) tick(1'b1, 16'h0, 4'h0);

    // Reset in the middle of a button 3 debounce.
    for (int n = 1; n < 100; n++) tick(1'b1, 16'h0, 4'b1000);
    for (int n = 0; n < 3; n++) begin
      tick(1'b0, 16'h0, 4'b1000);
      check("mid_reset_word", registro_switches_o, 32'h0);
    end
    rise_n = 0;
    for (int n = 1; n <= 300; n++) begin
      tick(1'b1, 16'h0, 4'b1000);
      if (rise_n == 0 && registro_switches_o[19]) rise_n = n;
    end
    check("post_reset_latency", rise_n, LAT);
    for (int n = 0; n < 300; n++) tick(1'b1, 16'h0, 4'h0);

    // Random traffic: mixed short and long button holds, occasional reset.
    sw = '0; bt = '0;
    for (int i = 0; i < 4; i++) hold[i] = 1;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 2) == 0) sw = 16'($urandom);
      for (int i = 0; i < 4; i++) begin
        hold[i]--;
        if (hold[i] <= 0) begin
          bt[i]   = ~bt[i];
          hold[i] = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 40))
                                                : int'($urandom_range(200, 400));
        end
      end
      tick(($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1, sw, bt);
    end

    #2;
    check("queue_drained", exp_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
